// File: rtl/coe_sram_arbiter.sv
// coe_sram_arbiter: arbitrates two read channels and one coefficient writer onto a single async SRAM port.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin read arbitration (default is fixed priority, channel 0 first).
module coe_sram_arbiter #(
    parameter int WR_STARVE_MAX = 16
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_rd0_req,
    input  logic [17:0] i_rd0_addr,
    output logic [15:0] o_rd0_data,
    output logic        o_rd0_valid,
    input  logic        i_rd1_req,
    input  logic [17:0] i_rd1_addr,
    output logic [15:0] o_rd1_data,
    output logic        o_rd1_valid,
    input  logic        i_wr_req,
    input  logic [17:0] i_wr_addr,
    input  logic [15:0] i_wr_data,
    output logic        o_wr_ack,
    output logic [17:0] o_sram_addr,
    output logic [15:0] o_sram_wdata,
    input  logic [15:0] i_sram_rdata,
    output logic        o_sram_ce_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

    state_t      state_q, state_d;
    logic        ch_q, ch_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ce_n_q, oe_n_q, we_n_q;
    logic        ce_n_d, oe_n_d, we_n_d;
    logic [15:0] rd0_data_q, rd1_data_q, rd0_data_d, rd1_data_d;
    logic        rd0_valid_q, rd1_valid_q, wr_ack_q;
    logic        rd0_valid_d, rd1_valid_d, wr_ack_d;
    logic        elig0, elig1, eligw, wr_first, pick1, gnt_rd, gnt_wr;
`ifdef ARB_ROUND_ROBIN_EN
    logic        ptr_q, ptr_d;
`endif

    // Eligibility masks out a requester whose completion pulse is visible this cycle
    always_comb begin
        elig0    = i_rd0_req & ~rd0_valid_q;
        elig1    = i_rd1_req & ~rd1_valid_q;
        eligw    = i_wr_req & ~wr_ack_q;
        wr_first = eligw && (32'(cnt_q) >= WR_STARVE_MAX);
`ifdef ARB_ROUND_ROBIN_EN
        pick1    = elig1 & (~elig0 | ptr_q);
`else
        pick1    = elig1 & ~elig0;
`endif
    end

    // Next-state and grant decision; one transaction in flight at a time
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        gnt_rd  = 1'b0;
        gnt_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_first) begin
                    state_d = WR_SETUP;
                    gnt_wr  = 1'b1;
                end else if (elig0 | elig1) begin
                    state_d = RD_ADDR;
                    gnt_rd  = 1'b1;
                    ch_d    = pick1;
                end else if (eligw) begin
                    state_d = WR_SETUP;
                    gnt_wr  = 1'b1;
                end
            end
            RD_ADDR:  state_d = RD_WAIT;
            RD_WAIT:  state_d = RD_CAP;
            RD_CAP:   state_d = IDLE;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath next values: address/data captured only at grant, strobes decoded from the next state
    always_comb begin
        cnt_d       = (!i_wr_req || gnt_wr) ? 8'd0 : (cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1);
        addr_d      = gnt_wr ? i_wr_addr : gnt_rd ? (pick1 ? i_rd1_addr : i_rd0_addr) : addr_q;
        wdata_d     = gnt_wr ? i_wr_data : wdata_q;
        ce_n_d      = state_d == IDLE;
        oe_n_d      = !(state_d == RD_ADDR || state_d == RD_WAIT || state_d == RD_CAP);
        we_n_d      = state_d != WR_PULSE;
        rd0_valid_d = state_q == RD_CAP && !ch_q;
        rd1_valid_d = state_q == RD_CAP && ch_q;
        wr_ack_d    = state_q == WR_HOLD;
        rd0_data_d  = rd0_valid_d ? i_sram_rdata : rd0_data_q;
        rd1_data_d  = rd1_valid_d ? i_sram_rdata : rd1_data_q;
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Priority moves to the other channel after every read grant
    always_comb begin
        ptr_d = gnt_rd ? ~pick1 : ptr_q;
    end

    // Round-robin pointer register
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) ptr_q <= 1'b0;
        else          ptr_q <= ptr_d;
    end
`endif

    // FSM state, served channel and starvation counter
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ch_q    <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
        end
    end

    // SRAM-side registers; async reset forces the strobes inactive immediately
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    // Requester-side results and completion pulses
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd0_data_q  <= '0;
            rd1_data_q  <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
            wr_ack_q    <= 1'b0;
        end else begin
            rd0_data_q  <= rd0_data_d;
            rd1_data_q  <= rd1_data_d;
            rd0_valid_q <= rd0_valid_d;
            rd1_valid_q <= rd1_valid_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    assign o_rd0_data   = rd0_data_q;
    assign o_rd1_data   = rd1_data_q;
    assign o_rd0_valid  = rd0_valid_q;
    assign o_rd1_valid  = rd1_valid_q;
    assign o_wr_ack     = wr_ack_q;
    assign o_sram_addr  = addr_q;
    assign o_sram_wdata = wdata_q;
    assign o_sram_ce_n  = ce_n_q;
    assign o_sram_oe_n  = oe_n_q;
    assign o_sram_we_n  = we_n_q;

endmodule

// File: tb/tb_coe_sram_arbiter.sv
// tb_coe_sram_arbiter: randomized bench for coe_sram_arbiter against a transaction-level reference model.
module tb_coe_sram_arbiter;

    localparam int WSM = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd0_req = 0, rd1_req = 0, wr_req = 0;
    logic [17:0] rd0_addr = 0, rd1_addr = 0, wr_addr = 0;
    logic [15:0] wr_data = 0, sram_rdata = 0;
    logic [15:0] rd0_data, rd1_data, sram_wdata;
    logic        rd0_valid, rd1_valid, wr_ack, ce_n, oe_n, we_n;
    logic [17:0] sram_addr;

    always #10 clk = ~clk;

    coe_sram_arbiter #(.WR_STARVE_MAX(WSM)) dut (
        .i_clk_50m(clk), .i_rst_n(rst_n),
        .i_rd0_req(rd0_req), .i_rd0_addr(rd0_addr), .o_rd0_data(rd0_data), .o_rd0_valid(rd0_valid),
        .i_rd1_req(rd1_req), .i_rd1_addr(rd1_addr), .o_rd1_data(rd1_data), .o_rd1_valid(rd1_valid),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
        .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata),
        .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n)
    );

    logic [15:0] sram [int];
    logic [15:0] mmem [int];

    int          n_cmp = 0, n_bad = 0;
    int          m_ph, m_kind, m_cnt;
    logic [17:0] m_addr;
    logic [15:0] m_wdata, m_d0, m_d1;
    logic        m_v0, m_v1, m_ack, m_last;

    function automatic logic [15:0] sram_val(int a);
        return sram.exists(a) ? sram[a] : 16'(a) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] mmem_val(int a);
        return mmem.exists(a) ? mmem[a] : 16'(a) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = -1; m_kind = 0; m_cnt = 0; m_addr = 0; m_wdata = 0;
        m_d0 = 0; m_d1 = 0; m_v0 = 0; m_v1 = 0; m_ack = 0; m_last = 1'b1;
    endtask

    task automatic check_outputs();
        check("rd0_valid", rd0_valid, m_v0);
        check("rd1_valid", rd1_valid, m_v1);
        check("wr_ack", wr_ack, m_ack);
        check("rd0_data", rd0_data, m_d0);
        check("rd1_data", rd1_data, m_d1);
        check("sram_addr", sram_addr, m_addr);
        check("sram_wdata", sram_wdata, m_wdata);
        check("ce_n", ce_n, m_ph < 0);
        check("oe_n", oe_n, !(m_ph >= 0 && m_kind < 2));
        check("we_n", we_n, !(m_ph == 1 && m_kind == 2));
        check("excl", 32'(rd0_valid) + 32'(rd1_valid) + 32'(wr_ack) <= 1, 1);
    endtask

    // one rising edge of the arbiter, from the request levels it will sample
    task automatic model_step();
        logic e0, e1, ew, n0, n1, na;
        int   g;
        e0 = rd0_req && !m_v0; e1 = rd1_req && !m_v1; ew = wr_req && !m_ack;
        n0 = 0; n1 = 0; na = 0; g = -1;
        if (m_ph == 2) begin
            if (m_kind == 0) begin m_d0 = mmem_val(int'(m_addr)); n0 = 1; end
            else if (m_kind == 1) begin m_d1 = mmem_val(int'(m_addr)); n1 = 1; end
            else na = 1;
            m_ph = -1;
        end else if (m_ph >= 0) m_ph++;
        else begin
            if (ew && m_cnt >= WSM) g = 2;
`ifdef ARB_ROUND_ROBIN_EN
            else if (e0 && e1) g = m_last ? 0 : 1;
`else
            else if (e0 && e1) g = 0;
`endif
            else if (e0) g = 0;
            else if (e1) g = 1;
            else if (ew) g = 2;
            if (g >= 0) begin
                m_ph = 0; m_kind = g;
                m_addr = g == 0 ? rd0_addr : g == 1 ? rd1_addr : wr_addr;
                if (g == 2) begin m_wdata = wr_data; mmem[int'(wr_addr)] = wr_data; end
                else m_last = (g == 1);
            end
        end
        m_cnt = (!wr_req || g == 2) ? 0 : (m_cnt < 255 ? m_cnt + 1 : 255);
        m_v0 = n0; m_v1 = n1; m_ack = na;
    endtask

    function automatic logic [17:0] rand_addr();
        return 18'h10000 + 18'($urandom_range(0, 7) * 16);
    endfunction

    // requesters obey the level protocol: hold until completion, may withdraw before grant
    task automatic drive(input int pr, input int pd, input int pw, input bit hold);
        if (rd0_req && rd0_valid && !hold) rd0_req = 0;
        else if (!rd0_req && $urandom_range(0, 99) < pr) begin rd0_req = 1; rd0_addr = rand_addr(); end
        else if (rd0_req && !rd0_valid && !(m_ph >= 0 && m_kind == 0) && $urandom_range(0, 99) < pd) rd0_req = 0;
        if (rd1_req && rd1_valid && !hold) rd1_req = 0;
        else if (!rd1_req && $urandom_range(0, 99) < pr) begin rd1_req = 1; rd1_addr = rand_addr(); end
        else if (rd1_req && !rd1_valid && !(m_ph >= 0 && m_kind == 1) && $urandom_range(0, 99) < pd) rd1_req = 0;
        if (wr_req && wr_ack) wr_req = 0;
        else if (!wr_req && $urandom_range(0, 99) < pw) begin wr_req = 1; wr_addr = rand_addr(); wr_data = 16'($urandom); end
        else if (wr_req && !(m_ph >= 0 && m_kind == 2) && $urandom_range(0, 99) < pd) wr_req = 0;
    endtask

    task automatic cycle(input int pr, input int pd, input int pw, input bit hold);
        drive(pr, pd, pw, hold);
        model_step();
        @(negedge clk);
        check_outputs();
        if (!we_n) sram[int'(sram_addr)] = sram_wdata;
        sram_rdata = sram_val(int'(sram_addr));
    endtask

    initial begin
        int n_oe, n_we, n_ack;
        bit rst_done;
        model_reset();
        sram[int'(18'h10040)] = 16'h1234;
        mmem[int'(18'h10040)] = 16'h1234;
        sram_rdata = sram_val(0);
        repeat (2) begin @(negedge clk); check_outputs(); end
        rst_n = 1;

        rd0_addr = 18'h10040; rd0_req = 1; n_oe = 0;
        repeat (8) begin cycle(0, 0, 0, 0); n_oe += int'(!oe_n); end
        check("single_rd_data", rd0_data, 16'h1234);
        check("single_rd_oe_cycles", n_oe, 3);

        wr_addr = 18'h10200; wr_data = 16'hF0A5; wr_req = 1; n_oe = 0; n_we = 0;
        repeat (8) begin
            cycle(0, 0, 0, 0);
            n_oe += int'(!oe_n);
            if (!we_n) begin
                n_we++;
                check("wr_pulse_addr", sram_addr, 18'h10200);
                check("wr_pulse_data", sram_wdata, 16'hF0A5);
            end
        end
        check("write_we_cycles", n_we, 1);
        check("write_no_oe", n_oe, 0);
        check("write_stored", sram_val(int'(18'h10200)), 16'hF0A5);

        rd0_req = 1; rd1_req = 1; rd0_addr = rand_addr(); rd1_addr = rand_addr();
        wr_req = 1; wr_addr = rand_addr(); wr_data = 16'($urandom); n_ack = 0;
        repeat (60) begin cycle(0, 0, 0, 1); n_ack += int'(wr_ack); end
        check("starved_write_acked", n_ack > 0, 1);

        rst_done = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle(30, 5, 20, 0);
            if (!rst_done && i > 500 && m_ph == 1 && m_kind == 2) begin
                #3 rst_n = 0;
                model_reset();
                #1 check("rst_we_n_async", we_n, 1);
                check_outputs();
                @(negedge clk);
                check_outputs();
                rst_n = 1;
                rst_done = 1;
            end
        end
        check("reset_injected", rst_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coe_sram_arbiter.md
COE_SRAM_ARBITER -- requirements
Module: coe_sram_arbiter

Interface
REQ-001 Parameter: WR_STARVE_MAX, 16, number of cycles a pending write waits before it takes priority over reads.
REQ-002 i_clk_50m  input  1  system clock, 50 MHz; all logic on the rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_rd0_req / i_rd1_req  input  1  read request, channel 0 / channel 1 (distance calculators); level, held until valid.
REQ-005 i_rd0_addr / i_rd1_addr  input  18  read address; stable while the matching request is high.
REQ-006 o_rd0_data / o_rd1_data  output  16  read data; held until the next read on that channel.
REQ-007 o_rd0_valid / o_rd1_valid  output  1  one-cycle read-complete pulse.
REQ-008 i_wr_req  input  1  coefficient loader write request; level, held until ack.
REQ-009 i_wr_addr / i_wr_data  input  18 / 16  write address and data; stable while i_wr_req is high.
REQ-010 o_wr_ack  output  1  one-cycle write-complete pulse.
REQ-011 o_sram_addr / o_sram_wdata  output  18 / 16  SRAM address and write data, registered.
REQ-012 i_sram_rdata  input  16  SRAM read data.
REQ-013 o_sram_ce_n / o_sram_oe_n / o_sram_we_n  output  1  SRAM strobes, active-low, registered.

Function
REQ-014 FSM states: IDLE, RD_ADDR, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD. Exactly one transaction is in flight at a time.
REQ-015 Read path: IDLE grant -> RD_ADDR (addr latched; ce_n=0, oe_n=0) -> RD_WAIT -> RD_CAP. In RD_CAP, i_sram_rdata is latched into o_rdX_data, o_rdX_valid pulses on the next cycle, and the FSM returns to IDLE.
REQ-016 Read latency: o_rdX_valid is high exactly 3 edges after the edge on which IDLE samples the granted request; throughput is 1 read per 4 cycles.
REQ-017 Write path: IDLE grant -> WR_SETUP (addr/wdata latched; ce_n=0, we_n=1) -> WR_PULSE (we_n=0) -> WR_HOLD (we_n=1; o_wr_ack pulses the next cycle) -> IDLE. oe_n stays 1 throughout a write.
REQ-018 In IDLE: ce_n=oe_n=we_n=1. o_sram_addr holds its last value.
REQ-019 Grant order in IDLE:
  - If the starvation counter is >= WR_STARVE_MAX and i_wr_req is high, the writer wins.
  - Otherwise reads win over the write.
  - Between two simultaneous reads, the winner is set by the REQ-030 policy.
  - The writer is granted only when no eligible read is pending.
REQ-020 Starvation counter (8 bit, saturating):
  - Increments each cycle i_wr_req is high and the writer is not granted.
  - Clears on write grant or when i_wr_req is low.
REQ-021 A channel whose valid or ack is high in the current cycle is ineligible in that cycle's IDLE decision. This prevents a duplicate grant while the requester is dropping its request.
REQ-022 Requests that drop before grant are ignored; no transaction is issued.
REQ-023 Address and data are sampled only at grant. Later changes do not affect the transaction in flight.
REQ-024 o_rd0_valid, o_rd1_valid and o_wr_ack are never high in the same cycle.

Reset
REQ-025 While i_rst_n is low:
  - FSM = IDLE.
  - Strobes = 1.
  - o_sram_addr = 0, o_sram_wdata = 0.
  - o_rd0_data = o_rd1_data = 0.
  - valids and ack = 0.
  - Starvation counter = 0.
  - Round-robin pointer = channel 0.
REQ-026 Reset asserted mid-transaction aborts it. we_n returns to 1 asynchronously, and no valid or ack is issued for the aborted transaction.
REQ-027 After reset release, the first grant occurs no earlier than the first rising edge with i_rst_n high.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN selects the read arbitration policy.
REQ-029 Without ARB_ROUND_ROBIN_EN: fixed priority, channel 0 over channel 1.
REQ-030 With ARB_ROUND_ROBIN_EN:
  - On simultaneous reads, the channel not most recently served wins.
  - The pointer updates at each read grant.
  - A single requester is always granted.

Verification
REQ-031 Single read: i_rd0_addr=18'h10040, SRAM returns 16'h1234 -> o_rd0_valid high 3 edges after the request is sampled; o_rd0_data=16'h1234; oe_n low for exactly 3 cycles.
REQ-032 Simultaneous reads held continuously:
  - With ARB_ROUND_ROBIN_EN: grants alternate 0,1,0,1.
  - Without ARB_ROUND_ROBIN_EN: only channel 0 is served while it requests.
REQ-033 Write with reads busy: i_wr_req held, both reads requesting continuously -> write granted once the counter reaches 16; o_wr_ack pulses; we_n is low for exactly 1 cycle with addr/data stable.
REQ-034 Write alone: addr 18'h10200, data 16'hF0A5 -> sequence WR_SETUP, WR_PULSE, WR_HOLD; o_wr_ack 3 edges after grant; no read strobes.
REQ-035 Reset mid-write: i_rst_n pulsed low during WR_PULSE -> we_n=1 immediately; no o_wr_ack; all outputs at reset values; normal operation resumes after release.
